// File: rtl/grid_renderer_pkg.sv
// Shared definitions for the grid renderer: controller state encoding,
// command kind constants and default colours.
package grid_renderer_pkg;

  // One-hot controller states
  typedef enum logic [5:0] {
    ST_WAIT_ADAPTER     = 6'b000001,
    ST_CLEAR            = 6'b000010,
    ST_DRAW_CURSOR_INIT = 6'b000100,
    ST_IDLE             = 6'b001000,
    ST_POP              = 6'b010000,
    ST_DRAW_CELL        = 6'b100000
  } state_e;

  localparam logic CMD_PAINT = 1'b0;
  localparam logic CMD_MOVE  = 1'b1;

  localparam logic [8:0] DEF_BG_COLOR     = 9'h1FF;
  localparam logic [8:0] DEF_CURSOR_COLOR = 9'h1C0;

endpackage

// File: rtl/grid_renderer_cmd_fifo.sv
// cmd_fifo: synchronous command queue with the head word held in a register
// (show-ahead). Ports: clk_i/rst_ni (async active-low flush), push_i/data_i
// write side (ignored when full), pop_i/data_o/empty_o read side, full_o.
module cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: draws a COLS x ROWS grid of square cells into a pixel frame
// buffer, one pixel per cycle. After adapter_ready it clears the whole grid,
// then draws the cursor ring on cell (0,0). Queued PAINT/MOVE commands then
// redraw individual cells.
// Ports: CLOCK_50/nReset clock and async active-low reset; adapter_ready
// frame-buffer ready; cmd_valid/cmd_ready/cmd_kind/cmd_col/cmd_row/cmd_color
// command handshake; busy, cmd_err status; pix_x/pix_y/pix_color/pix_write
// registered pixel write port.
module grid_renderer
  import grid_renderer_pkg::*;
#(
  parameter int unsigned COLS         = 12,
  parameter int unsigned ROWS         = 12,
  parameter int unsigned CELL         = 31,
  parameter int unsigned PITCH        = 33,
  parameter int unsigned X0           = 214,
  parameter int unsigned Y0           = 32,
  parameter int unsigned COLOR_DEPTH  = 9,
  parameter int unsigned BORDER       = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR     = COLOR_DEPTH'(DEF_BG_COLOR),
  parameter logic [COLOR_DEPTH-1:0] CURSOR_COLOR = COLOR_DEPTH'(DEF_CURSOR_COLOR)
) (
  input  logic                   CLOCK_50,
  input  logic                   nReset,
  input  logic                   adapter_ready,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_kind,
  input  logic [3:0]             cmd_col,
  input  logic [3:0]             cmd_row,
  input  logic [COLOR_DEPTH-1:0] cmd_color,
  output logic                   busy,
  output logic                   cmd_err,
  output logic [9:0]             pix_x,
  output logic [8:0]             pix_y,
  output logic [COLOR_DEPTH-1:0] pix_color,
  output logic                   pix_write
);

  localparam int unsigned AW = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1;
  localparam int unsigned FW = 9 + COLOR_DEPTH;

  if ((X0 + (COLS - 1) * PITCH + CELL > 640) || (Y0 + (ROWS - 1) * PITCH + CELL > 480)) begin : g_bad_geometry
    $error("grid_renderer: grid does not fit in 640x480");
  end

  state_e state_q, state_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic [5:0] dx_q, dx_d, dy_q, dy_d;
  logic [3:0] cur_col_q, cur_col_d, cur_row_q, cur_row_d;
  logic [3:0] nxt_col_q, nxt_col_d, nxt_row_q, nxt_row_d;
  logic       second_q, second_d;
  logic       alive_q;
  logic [9:0] pix_x_q, pix_x_d;
  logic [8:0] pix_y_q, pix_y_d;
  logic [COLOR_DEPTH-1:0] pix_color_q, pix_color_d;
  logic       pix_write_q, pix_write_d;

  logic [COLOR_DEPTH-1:0] ram_q [COLS*ROWS];
  logic                   ram_we;
  logic [AW-1:0]          ram_waddr;
  logic [COLOR_DEPTH-1:0] ram_wdata, ram_rdata;

  logic [FW-1:0] fifo_head;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic          hd_kind;
  logic [3:0]    hd_col, hd_row;
  logic [COLOR_DEPTH-1:0] hd_color;
  logic          hd_bad, cell_last, drawing, on_cursor, on_ring;

  function automatic logic [AW-1:0] cell_idx(input logic [3:0] c, input logic [3:0] r);
    return AW'(32'(r) * COLS + 32'(c));
  endfunction

  cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_ni  (nReset),
    .push_i  (cmd_valid & cmd_ready),
    .data_i  ({cmd_kind, cmd_col, cmd_row, cmd_color}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {hd_kind, hd_col, hd_row, hd_color} = fifo_head;
  assign hd_bad    = (32'(hd_col) >= COLS) || (32'(hd_row) >= ROWS);
  assign cmd_ready = alive_q & ~fifo_full;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_write = pix_write_q;
  assign ram_rdata = ram_q[cell_idx(col_q, row_q)];

  assign cell_last = (dx_q == 6'(CELL - 1)) && (dy_q == 6'(CELL - 1));
  assign drawing   = (state_q == ST_CLEAR) || (state_q == ST_DRAW_CURSOR_INIT) ||
                     (state_q == ST_DRAW_CELL);
  assign on_cursor = (col_q == cur_col_q) && (row_q == cur_row_q);
  assign on_ring   = (32'(dx_q) < BORDER) || (32'(dy_q) < BORDER) ||
                     (32'(dx_q) >= CELL - BORDER) || (32'(dy_q) >= CELL - BORDER);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    cur_col_d   = cur_col_q;
    cur_row_d   = cur_row_q;
    nxt_col_d   = nxt_col_q;
    nxt_row_d   = nxt_row_q;
    second_d    = second_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    pix_write_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = cell_idx(col_q, row_q);
    ram_wdata   = BG_COLOR;
    fifo_pop    = 1'b0;
    cmd_err     = 1'b0;

    if (drawing) begin
      pix_write_d = 1'b1;
      pix_x_d     = 10'(X0) + 10'(32'(col_q) * PITCH) + 10'(dx_q);
      pix_y_d     = 9'(Y0) + 9'(32'(row_q) * PITCH) + 9'(dy_q);
      if (state_q == ST_CLEAR)        pix_color_d = BG_COLOR;
      else if (on_cursor && on_ring)  pix_color_d = CURSOR_COLOR;
      else                            pix_color_d = ram_rdata;
      if (cell_last) begin
        dx_d = '0;
        dy_d = '0;
      end else if (dx_q == 6'(CELL - 1)) begin
        dx_d = '0;
        dy_d = dy_q + 6'd1;
      end else begin
        dx_d = dx_q + 6'd1;
      end
    end

    case (state_q)
      ST_WAIT_ADAPTER: if (adapter_ready) state_d = ST_CLEAR;
      ST_CLEAR: begin
        ram_we = 1'b1;
        if (cell_last) begin
          if (col_q == 4'(COLS - 1)) begin
            col_d = '0;
            if (row_q == 4'(ROWS - 1)) begin
              row_d     = '0;
              cur_col_d = '0;
              cur_row_d = '0;
              state_d   = ST_DRAW_CURSOR_INIT;
            end else begin
              row_d = row_q + 4'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      ST_DRAW_CURSOR_INIT: if (cell_last) state_d = ST_IDLE;
      ST_IDLE: if (!fifo_empty) state_d = ST_POP;
      ST_POP: begin
        fifo_pop = 1'b1;
        dx_d     = '0;
        dy_d     = '0;
        second_d = 1'b0;
        if (hd_bad) begin
          cmd_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAW_CELL;
          if (hd_kind == CMD_PAINT) begin
            ram_we    = 1'b1;
            ram_waddr = cell_idx(hd_col, hd_row);
            ram_wdata = hd_color;
            col_d     = hd_col;
            row_d     = hd_row;
          end else if (hd_col == cur_col_q && hd_row == cur_row_q) begin
            col_d = hd_col;
            row_d = hd_row;
          end else begin
            // Cursor moves now so the old cell's pass renders without a ring;
            // the new cell follows as a second pass.
            col_d     = cur_col_q;
            row_d     = cur_row_q;
            nxt_col_d = hd_col;
            nxt_row_d = hd_row;
            cur_col_d = hd_col;
            cur_row_d = hd_row;
            second_d  = 1'b1;
          end
        end
      end
      ST_DRAW_CELL: begin
        if (cell_last) begin
          if (second_q) begin
            col_d    = nxt_col_q;
            row_d    = nxt_row_q;
            second_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_WAIT_ADAPTER;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_WAIT_ADAPTER;
      col_q       <= '0;
      row_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
      nxt_col_q   <= '0;
      nxt_row_q   <= '0;
      second_q    <= 1'b0;
      alive_q     <= 1'b0;
      pix_x_q     <= 10'(X0);
      pix_y_q     <= 9'(Y0);
      pix_color_q <= BG_COLOR;
      pix_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
      nxt_col_q   <= nxt_col_d;
      nxt_row_q   <= nxt_row_d;
      second_q    <= second_d;
      alive_q     <= 1'b1;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      pix_write_q <= pix_write_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer on a reduced grid. A behavioural
// model turns each accepted command into the list of pixel writes it must
// produce; a monitor compares every pix_write against that list.
module tb_grid_renderer;

  localparam int COLS   = 6;
  localparam int ROWS   = 5;
  localparam int CELL   = 7;
  localparam int PITCH  = 9;
  localparam int X0     = 214;
  localparam int Y0     = 32;
  localparam int BORDER = 2;
  localparam int FDEPTH = 4;
  localparam logic [8:0] BG  = 9'h1FF;
  localparam logic [8:0] CUR = 9'h1C0;

  logic       CLOCK_50 = 1'b0;
  logic       nReset = 1'b0;
  logic       adapter_ready = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_kind = 1'b0;
  logic [3:0] cmd_col = '0;
  logic [3:0] cmd_row = '0;
  logic [8:0] cmd_color = '0;
  logic       cmd_ready, busy, cmd_err, pix_write;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [8:0] pix_color;

  always #10 CLOCK_50 = ~CLOCK_50;

  grid_renderer #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .PITCH(PITCH), .X0(X0), .Y0(Y0),
    .COLOR_DEPTH(9), .BORDER(BORDER), .FIFO_DEPTH(FDEPTH),
    .BG_COLOR(BG), .CURSOR_COLOR(CUR)
  ) dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset), .adapter_ready(adapter_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_color(cmd_color),
    .busy(busy), .cmd_err(cmd_err), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .pix_write(pix_write)
  );

  typedef struct packed {
    logic       first;
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] c;
  } px_t;

  px_t        expq[$];
  px_t        mon_e;
  logic [8:0] grid [COLS][ROWS];
  int         cur_c, cur_r;
  int         err_exp, err_seen;
  int         n_checks, n_errs;
  logic       prev_wr = 1'b0;
  logic       prev_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_draw(input int c, input int r, input bit ring);
    for (int dy = 0; dy < CELL; dy++) begin
      for (int dx = 0; dx < CELL; dx++) begin
        px_t p;
        bit  edge_px;
        edge_px = (dx < BORDER) || (dy < BORDER) || (dx >= CELL - BORDER) || (dy >= CELL - BORDER);
        p.first = (dx == 0) && (dy == 0);
        p.x     = 10'(X0 + c * PITCH + dx);
        p.y     = 9'(Y0 + r * PITCH + dy);
        p.c     = (ring && edge_px) ? CUR : grid[c][r];
        expq.push_back(p);
      end
    end
  endtask

  task automatic m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        grid[c][r] = BG;
        m_draw(c, r, 1'b0);
      end
    cur_c = 0;
    cur_r = 0;
    m_draw(0, 0, 1'b1);
  endtask

  task automatic m_cmd(input bit k, input int c, input int r, input logic [8:0] color);
    if (c >= COLS || r >= ROWS) begin
      err_exp++;
    end else if (k == 1'b0) begin
      grid[c][r] = color;
      m_draw(c, r, (c == cur_c) && (r == cur_r));
    end else if (c == cur_c && r == cur_r) begin
      m_draw(c, r, 1'b1);
    end else begin
      m_draw(cur_c, cur_r, 1'b0);
      cur_c = c;
      cur_r = r;
      m_draw(c, r, 1'b1);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLOCK_50) begin
    if (pix_write) begin
      if (expq.size() == 0) begin
        check_eq("px_unexpected", {4'b0, pix_x, pix_y, pix_color}, 32'h0);
      end else begin
        mon_e = expq.pop_front();
        check_eq("pixel", {4'b0, pix_x, pix_y, pix_color}, {4'b0, mon_e.x, mon_e.y, mon_e.c});
        if (!mon_e.first) check_eq("contig", {31'b0, prev_wr}, 32'd1);
      end
    end
    if (cmd_err) begin
      err_seen++;
      check_eq("err_width", {31'b0, prev_err}, 32'd0);
    end
    prev_wr  = pix_write;
    prev_err = cmd_err;
  end

  // ---------------- driver helpers ----------------
  task automatic send(input bit k, input int c, input int r, input logic [8:0] color);
    int n = 0;
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_col   = 4'(c);
    cmd_row   = 4'(r);
    cmd_color = color;
    while (!cmd_ready && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!cmd_ready) begin
      check_eq("send_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge CLOCK_50);
    m_cmd(k, c, r, color);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLOCK_50);
      if (!busy) break;
    end
    @(negedge CLOCK_50);
    #1;
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_pending"}, expq.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr"},    {31'b0, pix_write}, 32'd0);
    check_eq({tag, "_x"},     {22'b0, pix_x},     32'(X0));
    check_eq({tag, "_y"},     {23'b0, pix_y},     32'(Y0));
    check_eq({tag, "_color"}, {23'b0, pix_color}, {23'b0, BG});
    check_eq({tag, "_ready"}, {31'b0, cmd_ready}, 32'd0);
    check_eq({tag, "_busy"},  {31'b0, busy},      32'd1);
    check_eq({tag, "_err"},   {31'b0, cmd_err},   32'd0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit k;
    int c, r;

    // reset state and power-up clear
    repeat (3) @(negedge CLOCK_50);
    #1 check_reset_outputs("reset");
    @(negedge CLOCK_50);
    nReset = 1'b1;
    m_clear();
    repeat (2) @(negedge CLOCK_50);
    #1;
    check_eq("wait_ready", {31'b0, cmd_ready}, 32'd1);
    check_eq("wait_nowrite", {31'b0, pix_write}, 32'd0);
    repeat (2) @(negedge CLOCK_50);
    adapter_ready = 1'b1;
    wait_idle("clear");

    // PAINT with first-write latency
    send(1'b0, 3, 4, 9'd7);
    lat = 0;
    while (lat < 20) begin
      @(posedge CLOCK_50);
      #1 lat++;
      if (pix_write) break;
    end
    check_eq("latency", lat, 32'd3);
    wait_idle("paint");

    // MOVE off (0,0), MOVE onto current cursor
    send(1'b1, 1, 0, 9'd0);
    wait_idle("move");
    send(1'b1, 1, 0, 9'd0);
    wait_idle("move_same");

    // out-of-range commands, followed by normal ones
    send(1'b0, 12, 0, 9'h055);
    send(1'b0, 2, 1, 9'h0AA);
    send(1'b0, COLS, 2, 9'h011);
    send(1'b1, 0, ROWS, 9'h000);
    send(1'b1, 2, 1, 9'h000);
    wait_idle("err");
    check_eq("err_count", err_seen, err_exp);

    // reset in the middle of a cell with a command still queued
    send(1'b0, 5, 3, 9'h033);
    send(1'b0, 0, 4, 9'h100);
    repeat (10) @(posedge CLOCK_50);
    #2;
    nReset = 1'b0;
    adapter_ready = 1'b0;
    expq.delete();
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge CLOCK_50);
    nReset = 1'b1;
    m_clear();

    // fill the queue while the adapter is not ready
    send(1'b0, 1, 1, 9'h001);
    send(1'b1, 4, 2, 9'h000);
    send(1'b0, 4, 2, 9'h0F0);
    send(1'b0, 0, 0, 9'h00F);
    @(negedge CLOCK_50);
    #1;
    check_eq("ready_full", {31'b0, cmd_ready}, 32'd0);
    check_eq("nowrite_full", {31'b0, pix_write}, 32'd0);
    adapter_ready = 1'b1;
    send(1'b1, 0, 0, 9'h000);
    wait_idle("burst");

    // randomized commands with random gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      k = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 9) == 0) ? COLS : int'($urandom_range(0, COLS - 1));
      r = ($urandom_range(0, 9) == 0) ? ROWS : int'($urandom_range(0, ROWS - 1));
      send(k, c, r, 9'($urandom));
    end
    wait_idle("random");
    check_eq("err_total", err_seen, err_exp);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/grid_renderer.md
GRID_RENDERER -- requirements
Module: grid_renderer

Interface
REQ-001 Parameter COLS, 12, grid columns (1..16).
REQ-002 Parameter ROWS, 12, grid rows (1..16).
REQ-003 Parameter CELL, 31, cell side in pixels (4..63).
REQ-004 Parameter PITCH, 33, cell-to-cell stride in pixels (>= CELL).
REQ-005 Parameter X0, 214 / Y0, 32, pixel origin of cell (0,0).
REQ-006 Parameter COLOR_DEPTH, 9, pixel colour width.
REQ-007 Parameter BORDER, 2, cursor ring thickness in pixels (1..CELL/2).
REQ-008 Parameter FIFO_DEPTH, 4, command queue entries (power of 2).
REQ-009 Parameter BG_COLOR, 9'h1FF; CURSOR_COLOR, 9'h1C0.
REQ-010 CLOCK_50  in  1  system clock, all logic on rising edge.
REQ-011 nReset  in  1  reset, asynchronous, active-low.
REQ-012 adapter_ready  in  1  frame buffer ready (VGA_SYNC_N of adapter).
REQ-013 cmd_valid  in  1  command offered.
REQ-014 cmd_ready  out  1  queue can accept; transfer when valid & ready.
REQ-015 cmd_kind  in  1  0 = PAINT cell, 1 = MOVE cursor.
REQ-016 cmd_col / cmd_row  in  4 / 4  target cell.
REQ-017 cmd_color  in  COLOR_DEPTH  PAINT colour (ignored for MOVE).
REQ-018 busy  out  1  high whenever not IDLE or queue non-empty.
REQ-019 cmd_err  out  1  one-cycle pulse on out-of-range command.
REQ-020 pix_x / pix_y  out  10 / 9  pixel address to adapter.
REQ-021 pix_color  out  COLOR_DEPTH  pixel colour.
REQ-022 pix_write  out  1  write strobe, one pixel per asserted cycle.

Function
REQ-023 States: WAIT_ADAPTER, CLEAR, DRAW_CURSOR_INIT, IDLE, POP, DRAW_CELL; one-hot.
REQ-024 WAIT_ADAPTER -> CLEAR when adapter_ready = 1.
REQ-025 CLEAR writes every cell, row-major, dx/dy raster inner, BG_COLOR, one pixel/cycle; colour RAM (COLS*ROWS x COLOR_DEPTH) set to BG_COLOR.
REQ-026 After the last CLEAR pixel, cursor = (0,0), cell (0,0) drawn with ring; then IDLE.
REQ-027 IDLE -> POP when queue non-empty; POP reads head, DRAW_CELL begins next cycle.
REQ-028 Pixel address = X0 + col*PITCH + dx, Y0 + row*PITCH + dy, dx,dy in 0..CELL-1; pix_x/pix_y/pix_color/pix_write registered together.
REQ-029 Pixel colour = CURSOR_COLOR if cell == cursor and (dx<BORDER or dy<BORDER or dx>=CELL-BORDER or dy>=CELL-BORDER), else colour RAM entry.
REQ-030 PAINT: write cmd_color to RAM, then draw the cell (CELL*CELL writes).
REQ-031 MOVE: draw old cursor cell without ring, update cursor, draw new cell with ring (2*CELL*CELL writes); MOVE to current cursor cell draws once.
REQ-032 First pix_write of a command 2 cycles after POP entry; pix_write contiguous within a cell.
REQ-033 Out-of-range (col>=COLS or row>=ROWS) commands are accepted, popped, produce no writes, pulse cmd_err in the POP cycle.
REQ-034 cmd_ready = queue not full, in every state including WAIT_ADAPTER and CLEAR.
REQ-035 Full queue: cmd_ready low, offered command held by producer; pop and push in same cycle only when not full.
REQ-036 Elaboration error if X0+(COLS-1)*PITCH+CELL > 640 or Y0+(ROWS-1)*PITCH+CELL > 480.

Reset
REQ-037 nReset low: state WAIT_ADAPTER, queue flushed, cursor (0,0), counters 0, pix_write 0, pix_x X0, pix_y Y0, pix_color BG_COLOR, cmd_ready 0, busy 1, cmd_err 0.
REQ-038 Reset mid-draw abandons the cell; full CLEAR repeats after release.

Structure
REQ-039 Package grid_renderer_pkg: state encodings, cmd_kind constants, default colour constants.
REQ-040 Sub-module cmd_fifo (parametrised width/depth, synchronous, first-word registered) holds commands.

Verification
REQ-041 Reset, adapter_ready high at cycle 5 -> exactly 12*12*961 BG pixels then 961 cursor-cell pixels, ring pixels = 9'h1C0, busy falls after.
REQ-042 PAINT (3,4,9'd7) -> 961 writes, x 313..343, y 164..194, all 9'd7.
REQ-043 MOVE (1,0) after REQ-042 -> cell (0,0) rewritten all BG, then cell (1,0) x 247..277 with 2-pixel red ring.
REQ-044 Five commands back-to-back, FIFO_DEPTH 4 -> cmd_ready low after fourth, all five executed in order.
REQ-045 PAINT (12,0) -> cmd_err one pulse, zero pix_write, next command executes normally.
REQ-046 nReset pulse mid-cell -> pix_write 0 immediately, queue empty, CLEAR restarts on adapter_ready.
